// File: rtl/dm_pkg.sv
// Shared types and constants for the data-memory responder.
// The address check lives here so every user applies the same alignment and range rules.
package dm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dm_state_t;

    localparam int         DM_WAIT_W   = 4;
    localparam logic [1:0] DM_ALIGN_OK = 2'b00;

    // An access is rejected when it is not word-aligned or falls beyond the RAM.
    function automatic logic dm_addr_err(input logic [31:0] addr, input int unsigned addr_w);
        logic [31:0] hi;
        hi = addr >> (addr_w + 2);
        return (addr[1:0] != DM_ALIGN_OK) || (hi != '0);
    endfunction

endpackage

// File: rtl/dm_ram.sv
// Single-port synchronous word RAM, 2^ADDR_W x 32.
// dout only updates on an enabled read, so it holds the last read word across writes.
module dm_ram #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] idx,
    input  logic [31:0]       din,
    output logic [31:0]       dout
);

    logic [31:0] mem [2**ADDR_W];

    // NOTE: the array has no reset; clearing it would stop the RAM mapping onto block memory.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[idx] <= din;
            end else begin
                dout <= mem[idx];
            end
        end
    end

endmodule

// File: rtl/dm_resp.sv
// Data-memory responder: accepts one word request, waits WAIT_N cycles, then pulses ready
// with read data or an error flag.
module dm_resp
    import dm_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int WAIT_N = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic        busy
);

    localparam logic [DM_WAIT_W-1:0] WAIT_INIT = DM_WAIT_W'(WAIT_N);
    localparam logic [DM_WAIT_W-1:0] CNT_ONE   = DM_WAIT_W'(1);

    dm_state_t            state_q, state_d;
    logic [DM_WAIT_W-1:0] cnt_q, cnt_d;
    logic                 ready_q, ready_d;
    logic                 err_q, err_d;
    logic                 rzero_q, rzero_d;
    logic                 we_q;
    logic [31:0]          addr_q, wdata_q;

    logic                 enter_resp;
    logic                 acc_we;
    logic [31:0]          acc_addr;
    logic                 acc_err;
    logic                 ram_rd, ram_wr, ram_en;
    logic [31:0]          ram_dout;

    // With WAIT_N=0 the read is issued on the accept edge, before the latches hold the request.
    assign acc_addr = (state_q == IDLE) ? addr : addr_q;
    assign acc_we   = (state_q == IDLE) ? we   : we_q;
    assign acc_err  = dm_addr_err(acc_addr, ADDR_W);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_resp = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    cnt_d = WAIT_INIT;
                    if (WAIT_N == 0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready_d = enter_resp;
        err_d   = enter_resp & acc_err;
        rzero_d = rzero_q;
        if (enter_resp && !acc_we) begin
            rzero_d = acc_err;
        end
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rzero_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            rzero_q <= rzero_d;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == IDLE && req) begin
            we_q    <= we;
            addr_q  <= addr;
            wdata_q <= wdata;
        end
    end

    // Reset gates the enable so an abandoned write never reaches the array.
    assign ram_rd = enter_resp & ~acc_we & ~acc_err;
    assign ram_wr = (state_q == RESP) & we_q & ~err_q;
    assign ram_en = rst_n & (ram_rd | ram_wr);

    dm_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk  (clk),
        .en   (ram_en),
        .we   (ram_wr),
        .idx  (acc_addr[ADDR_W+1:2]),
        .din  (wdata_q),
        .dout (ram_dout)
    );

    assign rdata = rzero_q ? '0 : ram_dout;
    assign ready = ready_q;
    assign err   = err_q;
    assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_dm_resp.sv
// Randomized self-checking bench for dm_resp, run against three WAIT_N settings at once.
// Expected results come from a word-array memory model and the documented timing rules.
module tb_dm_resp;

    localparam int N = 3;
    localparam int WN [N] = '{1, 0, 3};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_s   [N];
    logic        we_s    [N];
    logic [31:0] addr_s  [N];
    logic [31:0] wdata_s [N];
    logic [31:0] rdata_s [N];
    logic        ready_s [N];
    logic        err_s   [N];
    logic        busy_s  [N];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        dm_resp #(
            .ADDR_W (10),
            .WAIT_N (WN[g])
        ) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .req   (req_s[g]),
            .we    (we_s[g]),
            .addr  (addr_s[g]),
            .wdata (wdata_s[g]),
            .rdata (rdata_s[g]),
            .ready (ready_s[g]),
            .err   (err_s[g]),
            .busy  (busy_s[g])
        );
    end

    logic [31:0] mem_m      [N][1024];
    bit          known_m    [N][1024];
    logic [31:0] last_r     [N];
    bit          last_known [N];
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    // Called just after the accept edge: releases the request and checks the response.
    task automatic finish_txn(input int k, input bit w, input logic [31:0] a, input logic [31:0] d,
                              input logic [31:0] pa, input logic [31:0] pd);
        int lat;
        bit seen;
        bit e;
        int wi;
        #1;
        req_s[k]   = 1'b0;
        addr_s[k]  = pa;
        wdata_s[k] = pd;
        we_s[k]    = 1'($urandom_range(0, 1));
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            if (ready_s[k] === 1'b1) seen = 1'b1;
        end
        e  = (a % 4 != 0) || (a >= 32'h1000);
        wi = int'(a[11:2]);
        check("latency", lat, 1 + WN[k]);
        if (seen) begin
            check("err", err_s[k], e);
            check("busy_resp", busy_s[k], 1);
            if (!w) begin
                if (e) begin
                    last_r[k]     = '0;
                    last_known[k] = 1'b1;
                end else begin
                    last_r[k]     = mem_m[k][wi];
                    last_known[k] = known_m[k][wi];
                end
            end
            if (last_known[k]) check("rdata", rdata_s[k], last_r[k]);
            if (w && !e) begin
                mem_m[k][wi]   = d;
                known_m[k][wi] = 1'b1;
            end
        end
        @(negedge clk);
        check("ready_pulse", ready_s[k], 0);
        check("busy_idle", busy_s[k], 0);
    endtask

    task automatic txn_p(input int k, input bit w, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] pa, input logic [31:0] pd);
        @(negedge clk);
        req_s[k]   = 1'b1;
        we_s[k]    = w;
        addr_s[k]  = a;
        wdata_s[k] = d;
        @(posedge clk);
        finish_txn(k, w, a, d, pa, pd);
    endtask

    task automatic txn(input int k, input bit w, input logic [31:0] a, input logic [31:0] d);
        txn_p(k, w, a, d, $urandom, $urandom);
    endtask

    initial begin
        int rdy_cnt;
        int k;
        int sel;
        logic [31:0] a;

        for (int i = 0; i < N; i++) begin
            req_s[i]      = 1'b0;
            we_s[i]       = 1'b0;
            addr_s[i]     = '0;
            wdata_s[i]    = '0;
            last_r[i]     = '0;
            last_known[i] = 1'b1;
        end

        // Reset held with a pending write request on instance 0.
        rst_n      = 1'b0;
        req_s[0]   = 1'b1;
        we_s[0]    = 1'b1;
        addr_s[0]  = 32'h40;
        wdata_s[0] = 32'h600D_0000;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("rst_ready", ready_s[0], 0);
            check("rst_err", err_s[0], 0);
            check("rst_busy", busy_s[0], 0);
            check("rst_rdata", rdata_s[0], 0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        finish_txn(0, 1'b1, 32'h40, 32'h600D_0000, $urandom, $urandom);
        txn(0, 1'b0, 32'h40, 0);

        // Write then read at WAIT_N=1.
        txn(0, 1'b1, 32'h10, 32'hDEAD_BEEF);
        txn(0, 1'b0, 32'h10, 0);

        // Rejected accesses, including the first word past the end.
        txn(0, 1'b1, 32'h0, 32'hCAFE_0000);
        txn(0, 1'b0, 32'h12, 0);
        txn(0, 1'b1, 32'h1000, 32'h1234_5678);
        txn(0, 1'b0, 32'h0, 0);
        txn(0, 1'b1, 32'hFFC, 32'h0BAD_F00D);
        txn(0, 1'b0, 32'hFFC, 0);

        // Back-to-back reads at WAIT_N=0 with req held high.
        for (int i = 0; i < 4; i++) txn(1, 1'b1, 32'(4 * i), 32'(i + 1));
        @(negedge clk);
        req_s[1]  = 1'b1;
        we_s[1]   = 1'b0;
        addr_s[1] = 32'h0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (i == 3) req_s[1] = 1'b0;
            else addr_s[1] = 32'(4 * (i + 1));
            @(negedge clk);
            check("b2b_ready", ready_s[1], 1);
            check("b2b_rdata", rdata_s[1], 32'(i + 1));
            @(negedge clk);
            check("b2b_gap", ready_s[1], 0);
        end
        last_r[1]     = 32'd4;
        last_known[1] = 1'b1;

        // Inputs change right after acceptance; the latched request must win.
        txn(0, 1'b1, 32'h20, 32'h5A5A_0000);
        txn_p(0, 1'b1, 32'h4, 32'hA5A5_A5A5, 32'h20, 32'h0);
        txn(0, 1'b0, 32'h4, 0);
        txn(0, 1'b0, 32'h20, 0);

        // Reset during the second WAIT cycle abandons the write.
        txn(2, 1'b1, 32'h8, 32'h1111_1111);
        @(negedge clk);
        req_s[2]   = 1'b1;
        we_s[2]    = 1'b1;
        addr_s[2]  = 32'h8;
        wdata_s[2] = 32'hFFFF_FFFF;
        @(posedge clk);
        #1 req_s[2] = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        rdy_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (ready_s[2] === 1'b1) rdy_cnt++;
        end
        check("rst_mid_noready", rdy_cnt, 0);
        check("rst_mid_busy", busy_s[2], 0);
        for (int i = 0; i < N; i++) begin
            last_r[i]     = '0;
            last_known[i] = 1'b1;
        end
        txn(2, 1'b0, 32'h8, 0);

        // Random traffic over a small window plus error and boundary addresses.
        repeat (300) begin
            k   = $urandom_range(0, N - 1);
            sel = $urandom_range(0, 9);
            case (sel)
                0:       a = {26'($urandom_range(0, 15)), 6'h0} | 32'($urandom_range(1, 3));
                1:       a = 32'h1000 | ($urandom & 32'hFFFF_F000);
                2:       a = 32'hFFC;
                default: a = 32'($urandom_range(0, 15)) << 2;
            endcase
            txn(k, 1'($urandom_range(0, 1)), a, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dm_resp.md
# dm_resp

Data-memory responder for the multi-cycle MIPS core. It is the memory-side end of the controller's load/store path: it accepts one word read or write request per transaction, inserts a configurable number of wait states, and answers with a one-cycle `ready` pulse carrying read data or an error flag. It sits between the controller/datapath (MR/MW states) and the on-chip word RAM.

## Interface
- `ADDR_W`, default 10: log2 of RAM depth in 32-bit words (1024 words, byte range 0x0000–0x0FFF).
- `WAIT_N`, default 1: wait states inserted before `ready`, legal range 0–15.
- `clk` input, 1 bit: single clock, all logic on its rising edge.
- `rst_n` input, 1 bit: reset, synchronous and active-low.
- `req` input, 1 bit: transaction request, sampled only in IDLE.
- `we` input, 1 bit: 1 = write, 0 = read. Qualified by `req`.
- `addr` input, 32 bits: byte address.
- `wdata` input, 32 bits: write data.
- `rdata` output, 32 bits: read data, valid when `ready`=1, `we`=0, and `err`=0.
- `ready` output, 1 bit: one-cycle completion pulse.
- `err` output, 1 bit: valid with `ready`; set when the access was rejected.
- `busy` output, 1 bit: high in WAIT and RESP.

## Operation
- State machine: IDLE, WAIT, RESP.
- IDLE with `req`=1:
  - Latch `we`, `addr`, and `wdata`.
  - Load the wait counter with `WAIT_N`.
  - Go to WAIT if `WAIT_N`>0, else go to RESP.
- IDLE with `req`=0: stay in IDLE.
- WAIT: decrement the counter each cycle. Go to RESP in the cycle the counter reaches 1.
- RESP:
  - Drive `ready`=1 for exactly one cycle, then return to IDLE.
  - Always return to IDLE; never accept a new request directly from RESP.
- Error check uses the latched address. `err`=1 when either condition holds:
  - misaligned: `addr[1:0]`≠0;
  - out of range: any bit of `addr[31:ADDR_W+2]`≠0.
- Erroring writes do not modify RAM. Erroring reads return `rdata`=0.
- Word index is `addr[ADDR_W+1:2]`.
- Writes commit to RAM on the clock edge that ends RESP.
- `rdata` is registered and holds its value until the next successful read's RESP. Writes and errors do not change it; erroring reads set it to 0.
- Inputs are latched at acceptance. Changes to `req`, `addr`, `we`, or `wdata` after acceptance have no effect on the current transaction.
- Initiator rule: drop `req` in the cycle after `ready`. If `req` stays high, IDLE accepts it as a new transaction.
- Reset values:
  - state IDLE, counter 0;
  - `ready`=0, `err`=0, `busy`=0, `rdata`=0.
  - RAM contents are not reset.
- Reset mid-transaction: the transaction is abandoned, no RAM write occurs, and the next cycle starts in IDLE.

## Timing
- Request accepted on edge t, with IDLE and `req`=1.
- `ready` high in cycle t+1+`WAIT_N`; `rdata` and `err` are valid in that same cycle.
- Minimum spacing between accepts: 2+`WAIT_N` cycles. Back-to-back at `WAIT_N`=0 gives `ready` every 2nd cycle.
- `busy` rises in cycle t+1 and falls in the cycle after `ready`.
- RAM read is synchronous. The read is issued on the transition into RESP so data lands in the `rdata` register during RESP.
- `WAIT_N`=0 must work; there is no combinational path from `req` to `ready`.

## Structure
- Package `dm_pkg`:
  - state enum `dm_state_t` {IDLE, WAIT, RESP};
  - `DM_WAIT_W`=4 (counter width);
  - error-check constant for alignment mask 2'b00.
- Sub-module `dm_ram`: single-port synchronous RAM of 2^`ADDR_W` × 32, with ports `clk`, `en`, `we`, `idx`, `din`, `dout`. Holds no reset logic.
- `dm_resp` contains the FSM, the wait counter, the latch registers, the error logic, and the output registers.

## Test plan
- Reset check: with `rst_n`=0 for 2 cycles and `req`=1, `ready`/`err`/`busy` stay 0 and `rdata`=0. Releasing `rst_n` with `req`=1 gives the first accept on the next edge.
- Write then read, `WAIT_N`=1:
  - Write 0xDEADBEEF @0x0010: `ready` 2 cycles after accept, `err`=0.
  - Read @0x0010: `rdata`=0xDEADBEEF with `ready`, `err`=0.
- Errors:
  - Read @0x0012 (misaligned): `err`=1, `rdata`=0.
  - Write 0x12345678 @0x1000 (out of range, `ADDR_W`=10): `err`=1.
  - Subsequent read @0x0000 returns its prior value, showing the write did not alias.
- `WAIT_N`=0 back-to-back: hold `req`=1 for 4 reads @0x0,0x4,0x8,0xC, preloaded with 1,2,3,4. `ready` pulses on alternate cycles with `rdata` 1,2,3,4.
- Input stability: change `addr` to 0x0020 and `wdata` to 0 one cycle after accepting a write of 0xA5A5A5A5 @0x0004. A later read @0x0004 returns 0xA5A5A5A5, and @0x0020 is unchanged.
- Reset mid-operation: with `WAIT_N`=3, write 0xFFFFFFFF @0x0008 over prior value 0x11111111. Assert `rst_n`=0 in the second WAIT cycle: no `ready` appears, and a later read @0x0008 returns 0x11111111.
